// File: rtl/pong_pkg.sv
// Shared definitions for the pong game blocks: field geometry, LFSR width
// and the serve controller state encoding.
package pong_pkg;

    localparam int unsigned RAND_WIDTH  = 9;
    localparam int unsigned GAME_HEIGHT = 30;
    localparam int unsigned MARGIN      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        COUNT  = 2'd2,
        LAUNCH = 2'd3
    } serve_state_e;

endpackage

// File: rtl/ball_serve_if.sv
// Serve controller bus: LFSR/game inputs towards the controller and the launch
// parameters coming back to the ball motion logic.
interface ball_serve_if #(
    parameter int unsigned Y_WIDTH = 6
);
    logic [pong_pkg::RAND_WIDTH-1:0] i_Rand;
    logic                            i_Serve_Req;
    logic                            i_Scorer;
    logic                            i_Game_Active;
    logic [Y_WIDTH-1:0]              o_Ball_Y;
    logic                            o_Dir_X;
    logic                            o_Dir_Y;
    logic                            o_Serve_Valid;
    logic                            o_Busy;
    logic                            o_Rand_Stuck;

    modport master (
        output i_Rand, i_Serve_Req, i_Scorer, i_Game_Active,
        input  o_Ball_Y, o_Dir_X, o_Dir_Y, o_Serve_Valid, o_Busy, o_Rand_Stuck
    );

    modport slave (
        input  i_Rand, i_Serve_Req, i_Scorer, i_Game_Active,
        output o_Ball_Y, o_Dir_X, o_Dir_Y, o_Serve_Valid, o_Busy, o_Rand_Stuck
    );
endinterface

// File: rtl/serve_timer.sv
// Loadable down-counter with a registered zero flag; times the serve delay.
module serve_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] cnt_q;
    logic             zero_q;

    // Load has priority over decrement; zero tracks the value being written.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            zero_q <= (load_val_i == '0);
        end else if (dec_i) begin
            cnt_q  <= cnt_q - WIDTH'(1);
            zero_q <= (cnt_q == WIDTH'(1));
        end
    end

    assign zero_o = zero_q;
endmodule

// File: rtl/ball_serve_ctrl.sv
// Turns an LFSR sample into a ball serve (row, directions) after a fixed delay.
// Optional repeated-sample detection is enabled by defining SERVE_STUCK_CHECK_EN.
module ball_serve_ctrl #(
    parameter int unsigned GAME_HEIGHT = pong_pkg::GAME_HEIGHT,
    parameter int unsigned MARGIN      = pong_pkg::MARGIN,
    parameter int unsigned SERVE_DELAY = 25000000,
    parameter int unsigned Y_WIDTH     = 6
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    ball_serve_if.slave  bus
);
    import pong_pkg::*;

    localparam int unsigned ROW_SPAN = GAME_HEIGHT - 2 * MARGIN;
    localparam int unsigned R_WIDTH  = 6;

    serve_state_e       state_q;
    logic [R_WIDTH-1:0] r_q;
    logic [R_WIDTH-1:0] r_load;
    logic [Y_WIDTH-1:0] ball_y_q;
    logic               dir_x_q;
    logic               dir_y_q;
    logic               busy_q;
    logic               rand_stuck;
    logic               accept_c;
    logic               span_hit_c;
    logic               load_c;
    logic               dec_c;
    logic               timer_zero;
    logic               unused_rand;

    assign accept_c   = (state_q == IDLE) && bus.i_Serve_Req && bus.i_Game_Active;
    assign span_hit_c = (32'(r_q) >= ROW_SPAN);
    assign load_c     = (state_q == REDUCE) && bus.i_Game_Active && !span_hit_c;
    assign dec_c      = (state_q == COUNT) && bus.i_Game_Active && !timer_zero;
    assign unused_rand = ^bus.i_Rand[7:6];

`ifdef SERVE_STUCK_CHECK_EN
    logic [RAND_WIDTH-1:0] last_q;
    logic                  stuck_q;
    logic                  repeat_c;

    assign repeat_c = (bus.i_Rand == last_q);
    assign r_load   = repeat_c ? ~bus.i_Rand[R_WIDTH-1:0] : bus.i_Rand[R_WIDTH-1:0];

    // A repeated sample is inverted so the serve row still moves.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            last_q  <= '0;
            stuck_q <= 1'b0;
        end else if (accept_c) begin
            last_q  <= bus.i_Rand;
            stuck_q <= repeat_c;
        end
    end

    assign rand_stuck = stuck_q;
`else
    assign r_load     = bus.i_Rand[R_WIDTH-1:0];
    assign rand_stuck = 1'b0;
`endif

    serve_timer #(.WIDTH(32)) u_timer (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_n),
        .load_i     (load_c),
        .load_val_i (32'(SERVE_DELAY - 1)),
        .dec_i      (dec_c),
        .zero_o     (timer_zero)
    );

    // Serve sequencer; game inactive aborts REDUCE/COUNT but never LAUNCH.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            ball_y_q <= '0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        r_q     <= r_load;
                        dir_y_q <= bus.i_Rand[RAND_WIDTH-1];
                        dir_x_q <= ~bus.i_Scorer;
                        busy_q  <= 1'b1;
                        state_q <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (!bus.i_Game_Active) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (span_hit_c) begin
                        r_q <= r_q - R_WIDTH'(ROW_SPAN);
                    end else begin
                        ball_y_q <= Y_WIDTH'(MARGIN) + Y_WIDTH'(r_q);
                        state_q  <= COUNT;
                    end
                end
                COUNT: begin
                    if (!bus.i_Game_Active) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_zero) begin
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_Ball_Y      = ball_y_q;
    assign bus.o_Dir_X       = dir_x_q;
    assign bus.o_Dir_Y       = dir_y_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Rand_Stuck  = rand_stuck;
    assign bus.o_Serve_Valid = (state_q == LAUNCH);
endmodule

// File: tb/tb_ball_serve_ctrl.sv
// Self-checking bench for ball_serve_ctrl: directed and random serves against
// an arithmetic model of row selection, directions and launch latency.
module tb_ball_serve_ctrl;
    localparam int D      = 4;
    localparam int MARGIN = 2;
    localparam int SPAN   = 30 - 2 * MARGIN;

    typedef struct {
        int k;
        int y;
        bit dx;
        bit dy;
        bit stuck;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_serve_if #(.Y_WIDTH(6)) bus ();

    ball_serve_ctrl #(.SERVE_DELAY(D)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.slave)
    );

    int       n_cmp = 0;
    int       n_mis = 0;
    logic [8:0] last_acc = 9'd0;
    int       prev_y = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: row = MARGIN + r mod SPAN, one extra cycle per subtraction.
    task automatic model_accept(input logic [8:0] rv, input bit sc, output exp_t e);
        int r;
`ifdef SERVE_STUCK_CHECK_EN
        e.stuck = (rv == last_acc);
`else
        e.stuck = 1'b0;
`endif
        r       = e.stuck ? 63 - int'(rv[5:0]) : int'(rv[5:0]);
        e.k     = r / SPAN;
        e.y     = MARGIN + (r % SPAN);
        e.dx    = !sc;
        e.dy    = rv[8];
        last_acc = rv;
    endtask

    task automatic start(input logic [8:0] rv, input bit sc, output exp_t e);
        bus.i_Rand        = rv;
        bus.i_Scorer      = sc;
        bus.i_Game_Active = 1'b1;
        bus.i_Serve_Req   = 1'b1;
        tick();
        bus.i_Serve_Req = 1'b0;
        model_accept(rv, sc, e);
        check("busy_at_accept", 32'(bus.o_Busy), 32'd1);
        check("dir_x_at_accept", 32'(bus.o_Dir_X), 32'(e.dx));
        check("dir_y_at_accept", 32'(bus.o_Dir_Y), 32'(e.dy));
    endtask

    // Called one tick after the accepting edge; inj_at injects a stray request.
    task automatic wait_strobe(input exp_t e, input int inj_at);
        int t = 0;
        while (!bus.o_Serve_Valid && t < 200) begin
            bus.i_Serve_Req = (t == inj_at);
            tick();
            t++;
        end
        bus.i_Serve_Req = 1'b0;
        check("latency", 32'(t), 32'(1 + e.k + D));
        check("ball_y", 32'(bus.o_Ball_Y), 32'(e.y));
        check("dir_x", 32'(bus.o_Dir_X), 32'(e.dx));
        check("dir_y", 32'(bus.o_Dir_Y), 32'(e.dy));
        check("rand_stuck", 32'(bus.o_Rand_Stuck), 32'(e.stuck));
        check("busy_at_launch", 32'(bus.o_Busy), 32'd1);
        prev_y = e.y;
    endtask

    task automatic serve(input logic [8:0] rv, input bit sc, input bit inj);
        exp_t e;
        start(rv, sc, e);
        wait_strobe(e, inj ? e.k + 1 : -1);
        tick();
        check("strobe_one_cycle", 32'(bus.o_Serve_Valid), 32'd0);
        check("busy_after_launch", 32'(bus.o_Busy), 32'd0);
        tick();
        check("no_queued_serve", 32'(bus.o_Busy), 32'd0);
        check("y_hold", 32'(bus.o_Ball_Y), 32'(e.y));
    endtask

    task automatic abort_serve(input logic [8:0] rv, input bit in_count);
        exp_t e;
        int   strobes = 0;
        start(rv, 1'b0, e);
        if (in_count) begin
            repeat (e.k + 2) tick();
            prev_y = e.y;
        end
        bus.i_Game_Active = 1'b0;
        tick();
        check("abort_busy", 32'(bus.o_Busy), 32'd0);
        check("abort_y", 32'(bus.o_Ball_Y), 32'(prev_y));
        check("abort_dir_x", 32'(bus.o_Dir_X), 32'(e.dx));
        bus.i_Game_Active = 1'b1;
        repeat (D + 4) begin
            if (bus.o_Serve_Valid) strobes++;
            tick();
        end
        check("abort_no_strobe", 32'(strobes), 32'd0);
    endtask

    // Request held through LAUNCH is taken one cycle later.
    task automatic launch_hold(input logic [8:0] rv);
        exp_t e;
        exp_t e2;
        start(rv, 1'b1, e);
        wait_strobe(e, -1);
        bus.i_Serve_Req = 1'b1;
        tick();
        check("no_accept_in_launch", 32'(bus.o_Busy), 32'd0);
        tick();
        bus.i_Serve_Req = 1'b0;
        model_accept(rv, 1'b1, e2);
        check("accept_after_launch", 32'(bus.o_Busy), 32'd1);
        wait_strobe(e2, -1);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] all_out;
        bus.i_Rand        = 9'h1FF;
        bus.i_Scorer      = 1'b0;
        bus.i_Game_Active = 1'b1;
        bus.i_Serve_Req   = 1'b1;
        rst_n             = 1'b0;
        repeat (3) begin
            tick();
            all_out = 32'({bus.o_Ball_Y, bus.o_Dir_X, bus.o_Dir_Y, bus.o_Serve_Valid,
                           bus.o_Busy, bus.o_Rand_Stuck});
            check("reset_outputs", all_out, 32'd0);
        end
        bus.i_Serve_Req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(bus.o_Busy), 32'd0);

        serve(9'h105, 1'b0, 1'b0);
        serve(9'h03C, 1'b1, 1'b0);
        serve(9'h019, 1'b0, 1'b1);
        serve(9'h01A, 1'b1, 1'b0);
        abort_serve(9'h12B, 1'b1);
        abort_serve(9'h03E, 1'b0);
        launch_hold(9'h0F3);
        serve(9'h005, 1'b0, 1'b0);
        serve(9'h005, 1'b0, 1'b0);
        serve(9'h006, 1'b0, 1'b0);

        // Reset in the middle of a serve.
        bus.i_Rand = 9'h111; bus.i_Serve_Req = 1'b1;
        tick();
        bus.i_Serve_Req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        all_out = 32'({bus.o_Ball_Y, bus.o_Dir_X, bus.o_Dir_Y, bus.o_Serve_Valid,
                       bus.o_Busy, bus.o_Rand_Stuck});
        check("midserve_reset", all_out, 32'd0);
        rst_n = 1'b1;
        last_acc = 9'd0;
        prev_y = 0;
        tick();

        for (int i = 0; i < 40; i++) begin
            serve(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/ball_serve_ctrl.md
Name: ball_serve_ctrl

Overview:
Consumes the 9-bit pseudo-random value from the game's LFSR and turns it into a ball serve: a starting row, a vertical direction and a horizontal direction.
Sits between the LFSR and the ball motion logic.
On a serve request it samples the random value, range-reduces it into the playable rows, waits a fixed serve delay, then emits a one-cycle launch strobe with the launch parameters.

Parameters:
GAME_HEIGHT, 30, total rows in the play field
MARGIN, 2, rows excluded at top and bottom; ROW_SPAN = GAME_HEIGHT - 2*MARGIN, must be >= 1
SERVE_DELAY, 25000000, cycles between range-reduce completion and launch; must be >= 1
Y_WIDTH, 6, width of o_Ball_Y

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  synchronous reset, active-low
i_Rand  in  9  LFSR output, sampled only on an accepted request
i_Serve_Req  in  1  serve request, level or pulse
i_Scorer  in  1  player who just scored: 0 = left, 1 = right
i_Game_Active  in  1  game running; low aborts any serve in progress
o_Ball_Y  out  Y_WIDTH  starting row
o_Dir_X  out  1  1 = ball moves right
o_Dir_Y  out  1  1 = ball moves down
o_Serve_Valid  out  1  one-cycle launch strobe
o_Busy  out  1  serve in progress
o_Rand_Stuck  out  1  repeated-sample flag (see Optional Feature)

Behaviour:
- Reset: any cycle with i_Rst_n = 0 at the clock edge takes priority over all other inputs, including mid-serve.
  - State goes to IDLE.
  - All outputs, the internal r register and the counter go to 0.
- Clocking: single clock, all state on posedge i_Clk. Every output is registered except o_Serve_Valid, which is decoded from state == LAUNCH.
- IDLE:
  - A request is accepted at edge N when i_Serve_Req = 1 and i_Game_Active = 1.
  - On acceptance: r <= i_Rand[5:0]; o_Dir_Y <= i_Rand[8]; o_Dir_X <= ~i_Scorer; state goes to REDUCE.
  - o_Busy = 1 from cycle N+1.
- REDUCE, one check per cycle:
  - If r >= ROW_SPAN: r <= r - ROW_SPAN and stay in REDUCE.
  - Otherwise: o_Ball_Y <= MARGIN + r (zero-extended to Y_WIDTH); counter <= SERVE_DELAY-1; state goes to COUNT.
  - Worst case 3 cycles at defaults (max r = 63, ROW_SPAN = 26).
- COUNT:
  - counter == 0: go to LAUNCH.
  - Otherwise: decrement the counter.
  - COUNT lasts exactly SERVE_DELAY cycles.
- LAUNCH:
  - o_Serve_Valid = 1 for exactly this cycle; o_Busy stays 1.
  - Next state is IDLE; o_Busy = 0 from the next cycle.
- Latency: request at edge N with k subtractions gives o_Serve_Valid high in cycle N + 2 + k + SERVE_DELAY.
- Output hold: o_Ball_Y, o_Dir_X and o_Dir_Y hold their values after LAUNCH until overwritten by the next serve.
  - o_Dir_X and o_Dir_Y update at acceptance.
  - o_Ball_Y updates at REDUCE exit.
- Requests while busy: i_Serve_Req is ignored in every state except IDLE. There is no queueing.
- Abort: i_Game_Active = 0 in REDUCE or COUNT forces IDLE on the next edge.
  - No o_Serve_Valid is issued and o_Busy drops.
  - o_Ball_Y, o_Dir_X and o_Dir_Y keep their current values.
- LAUNCH never aborts; the strobe always completes.
- A request in the same cycle as LAUNCH is not accepted. It is accepted one cycle later if still held.

Optional Feature:
SERVE_STUCK_CHECK_EN
- Defined:
  - Register the last accepted 9-bit i_Rand value (reset 0).
  - If a newly accepted sample equals it: r loads ~i_Rand[5:0] instead of i_Rand[5:0], and o_Rand_Stuck <= 1.
  - Any non-matching acceptance clears o_Rand_Stuck to 0.
  - The last-sample register updates on every acceptance.
- Undefined: no compare logic; o_Rand_Stuck is constant 0.

Decomposition:
- Package pong_pkg:
  - state encoding IDLE/REDUCE/COUNT/LAUNCH (2 bits)
  - RAND_WIDTH = 9
  - default field constants GAME_HEIGHT and MARGIN, shared with the ball and paddle blocks
- Sub-module serve_timer: loadable down-counter with a zero flag, 32-bit, used for COUNT.

Test Plan:
- Reset: hold i_Rst_n = 0 for 3 cycles -> all outputs 0, and a request during reset is not accepted.
- Basic serve: SERVE_DELAY = 4, i_Rand = 9'h105, i_Scorer = 0, request at N -> o_Ball_Y = 7, o_Dir_X = 1, o_Dir_Y = 1, o_Serve_Valid high only in cycle N+6.
- Multi-subtract: i_Rand = 9'h03C (r = 60), i_Scorer = 1 -> r goes 60, 34, 8; o_Ball_Y = 10, o_Dir_X = 0, o_Dir_Y = 0; strobe at N+8.
- Busy and abort:
  - A second request during COUNT -> ignored, exactly one strobe.
  - Separately, drop i_Game_Active mid-COUNT -> no strobe, o_Busy = 0 next cycle, o_Ball_Y unchanged.
- Boundary: i_Rand[5:0] = 25 (ROW_SPAN-1) -> o_Ball_Y = 27; i_Rand[5:0] = 26 -> o_Ball_Y = 2.
- With SERVE_STUCK_CHECK_EN: two serves with i_Rand = 9'h005 -> the second serve gives o_Ball_Y = MARGIN + reduce(58) = 8 with o_Rand_Stuck = 1; a third serve with 9'h006 -> o_Rand_Stuck = 0.
